// File: rtl/vls_sequencer_if.sv
// Request, memory-bus and vector-serial-port signals between the opcode decoder/memory side and vls_sequencer.
// master drives requests and read data; slave (the sequencer) drives strobes, addresses and write data.
interface vls_sequencer_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          Start;
    logic          Op;
    logic [AW-1:0] BaseAddr;
    logic [2:0]    VRegSel;
    logic          Busy;
    logic          Done;
    logic [AW-1:0] Addr;
    logic          RD;
    logic          WR;
    logic [DW-1:0] DataOut;
    logic [DW-1:0] DataIn;
    logic [2:0]    vAddr;
    logic [3:0]    vElem;
    logic          vRD_s;
    logic          vWR_s;
    logic [DW-1:0] vInS;
    logic [DW-1:0] vOutS;

    modport master (
        output Start, Op, BaseAddr, VRegSel, DataIn, vOutS,
        input  Busy, Done, Addr, RD, WR, DataOut, vAddr, vElem, vRD_s, vWR_s, vInS
    );

    modport slave (
        input  Start, Op, BaseAddr, VRegSel, DataIn, vOutS,
        output Busy, Done, Addr, RD, WR, DataOut, vAddr, vElem, vRD_s, vWR_s, vInS
    );
endinterface

// File: rtl/vls_sequencer.sv
// Vector load/store sequencer: moves NELEM elements between memory and a vector register's serial port.
// Busy for NELEM+1 cycles after Start (Done in the last); no backpressure, Start while Busy is dropped.
module vls_sequencer #(
    parameter int NELEM = 16,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic          Clk1,
    input  logic          Reset,
    vls_sequencer_if.slave bus
);
    localparam int KW = $clog2(NELEM) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_STORE,
        S_TAIL
    } state_t;

    state_t        state_q;
    logic [KW-1:0] k_q;
    logic [KW-1:0] k_d;
    logic [KW-1:0] km1;
    logic          op_q;
    logic [AW-1:0] base_q;
    logic [2:0]    vreg_q;
    logic          last_k;

    logic          rd;
    logic          wr;
    logic          vrd;
    logic          vwr;
    logic [AW-1:0] addr;
    logic [3:0]    velem;
    logic [DW-1:0] wr_dat;
    logic [DW-1:0] vin_dat;

    assign k_d    = k_q + KW'(1);
    assign km1    = k_q - KW'(1);
    assign last_k = (k_q == KW'(NELEM - 1));

    // k runs on to NELEM in TAIL so the trailing write reuses the k-1 decode path.
    always_ff @(posedge Clk1 or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            op_q    <= 1'b0;
            base_q  <= '0;
            vreg_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.Start) begin
                        op_q    <= bus.Op;
                        base_q  <= bus.BaseAddr;
                        vreg_q  <= bus.VRegSel;
                        k_q     <= '0;
                        state_q <= bus.Op ? S_STORE : S_LOAD;
                    end
                end
                S_LOAD, S_STORE: begin
                    k_q <= k_d;
                    if (last_k) begin
                        state_q <= S_TAIL;
                    end
                end
                S_TAIL: begin
                    k_q     <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    k_q     <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rd    = (state_q == S_LOAD);
        vrd   = (state_q == S_STORE);
        vwr   = ((state_q == S_LOAD) && (k_q != '0)) || ((state_q == S_TAIL) && !op_q);
        wr    = ((state_q == S_STORE) && (k_q != '0)) || ((state_q == S_TAIL) && op_q);
        addr  = '0;
        velem = '0;
        if (rd) begin
            addr = base_q + AW'(k_q);
        end else if (wr) begin
            addr = base_q + AW'(km1);
        end
        if (vrd) begin
            velem = 4'(k_q);
        end else if (vwr) begin
            velem = 4'(km1);
        end
    end

    // Data paths are straight wires, held at zero outside their strobe so idle/reset buses read 0.
    assign wr_dat  = wr  ? bus.vOutS  : '0;
    assign vin_dat = vwr ? bus.DataIn : '0;

    assign bus.Busy    = (state_q != S_IDLE);
    assign bus.Done    = (state_q == S_TAIL);
    assign bus.RD      = rd;
    assign bus.WR      = wr;
    assign bus.vRD_s   = vrd;
    assign bus.vWR_s   = vwr;
    assign bus.Addr    = addr;
    assign bus.vElem   = velem;
    assign bus.vAddr   = (state_q != S_IDLE) ? vreg_q : 3'd0;
    assign bus.DataOut = wr_dat;
    assign bus.vInS    = vin_dat;
endmodule

// File: doc/vls_sequencer.md
Name: vls_sequencer

Overview:
- Sequences vector load (VLD) and vector store (VST) transfers between the 16-bit memory bus and the serial port of the vector register file.
- One vector is NELEM elements of 16 bits: 256 bits at the default NELEM = 16.
- The opcode decoder issues one request per instruction. The sequencer then owns Addr/RD/WR/DataOut and the vector serial port until it pulses Done.

Parameters:
- NELEM, 16, elements per vector; must be a power of 2 between 2 and 16.
- AW, 16, memory address width.
- DW, 16, element and memory data width.

Ports:
- Clk1  in  1  sole clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  request strobe; sampled only in IDLE.
- Op  in  1  transfer type: 0 = load (memory to vector register), 1 = store (vector register to memory).
- BaseAddr  in  AW  memory address of element 0; captured at Start.
- VRegSel  in  3  target vector register; captured at Start.
- Busy  out  1  high from the cycle after Start is accepted up to and including the Done cycle.
- Done  out  1  one-cycle completion pulse.
- Addr  out  AW  memory address.
- RD  out  1  memory read strobe; DataIn is valid in the following cycle.
- WR  out  1  memory write strobe; Addr and DataOut are valid in the same cycle.
- DataOut  out  DW  memory write data.
- DataIn  in  DW  memory read data.
- vAddr  out  3  vector register select.
- vElem  out  4  element index for the serial port.
- vRD_s  out  1  serial read strobe; vOutS is valid in the following cycle.
- vWR_s  out  1  serial write strobe; vInS is written to element vElem.
- vInS  out  DW  serial write data.
- vOutS  in  DW  serial read data.

Behaviour:
- States: IDLE, LOAD, STORE, TAIL.
  - State, counter k, op, base and vreg are registers.
  - Outputs are decoded from those registers.
  - vInS = DataIn and DataOut = vOutS are combinational pass-throughs.
- Reset (asserted, asynchronously): state = IDLE, k = 0.
  - Busy, Done, RD, WR, vRD_s and vWR_s are all 0.
  - Addr, DataOut, vInS, vAddr and vElem are all 0.
- IDLE:
  - All strobes are low.
  - Start = 1 at an edge captures Op/BaseAddr/VRegSel, clears k and enters LOAD (Op = 0) or STORE (Op = 1).
- LOAD, cycle k (k = 0 to NELEM-1):
  - RD = 1 and Addr = base + k.
  - When k ≥ 1, also vWR_s = 1 and vElem = k-1 (writing DataIn from the previous read).
  - After k = NELEM-1, go to TAIL.
- STORE, cycle k:
  - vRD_s = 1 and vElem = k.
  - When k ≥ 1, also WR = 1, Addr = base + k-1 and DataOut = vOutS.
  - After k = NELEM-1, go to TAIL.
- TAIL:
  - Performs the final write: vWR_s with vElem = NELEM-1 for a load, or WR with Addr = base + NELEM-1 for a store.
  - Done = 1 and Busy = 1 in this cycle; the next state is IDLE.
- Latency: Start accepted at edge t, so Busy is high for cycles t+1 through t+NELEM+1, and Done occurs at cycle t+NELEM+1.
- Address arithmetic is modulo 2^AW; base + k wraps silently with no error.
- vAddr holds the captured VRegSel while Busy and is 0 otherwise.
- Invariants:
  - RD and WR are never high together.
  - vRD_s and vWR_s are never high together.
  - Exactly NELEM memory strobes and NELEM serial strobes occur per operation.
- Start while Busy is ignored and is not queued.
- Start in the IDLE cycle right after Done is accepted, so back-to-back operations have no bubble beyond TAIL.
- Reset mid-operation aborts immediately:
  - Strobes drop asynchronously and no Done is issued.
  - Partially transferred data is left as written.
- Inputs changing while Busy have no effect; only the values captured at Start are used.

Test Plan:
1. Load, BaseAddr = 0x0100, VRegSel = 3, memory[0x0100 + i] = 0xA000 + i:
   - RD with Addr 0x0100 to 0x010F on cycles t+1 to t+16.
   - vWR_s with vElem 0 to 15 and vInS 0xA000 to 0xA00F on cycles t+2 to t+17.
   - Done at t+17, with Busy low at t+18.
2. Store, BaseAddr = 0xFFF8, vector register 5 holding 0x5000 + i:
   - WR Addr sequence is 0xFFF8 to 0xFFFF, then 0x0000 to 0x0007, with DataOut 0x5000 to 0x500F.
   - RD is never asserted.
3. Start held high for 5 cycles during a load:
   - Exactly one operation runs, with 16 RD strobes and one Done.
4. Reset driven low at cycle t+7 of a store:
   - All strobes and Busy go to 0 before the next edge, and no Done is produced.
   - A Start after Reset is released runs a full, correct transfer.
5. Load immediately followed by a store, with the second Start asserted in the cycle after Done:
   - Both complete.
   - Gap between the first Done and the second operation's first strobe is one cycle.
   - Total of 32 memory strobes and 2 Done pulses.
6. Random load/store mix against a memory and register-file model:
   - Every cycle: RD and WR never both high.
   - Strobe counts equal NELEM per operation.
   - Final memory and register contents match the model.
